// File: rtl/mc_cu_pkg.sv
// mc_cu_pkg: shared control definitions for the multicycle CPU.
// Holds FSM state codes, ALU operation codes, ALU B-source codes and
// PC-source codes. The datapath imports the same package, so both sides
// agree on every encoding. Also defines the decoded-instruction bundle
// and a helper that maps a decoded instruction to its ALU operation.
package mc_cu_pkg;

  // FSM state codes (3-bit, visible on the debug state port)
  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EXE = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  // ALU operation codes
  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  // ALU B-source select
  localparam logic [1:0] ASB_REG  = 2'b00;
  localparam logic [1:0] ASB_FOUR = 2'b01;
  localparam logic [1:0] ASB_IMM  = 2'b10;
  localparam logic [1:0] ASB_BOFS = 2'b11;

  // PC source select
  localparam logic [1:0] PCS_ALU  = 2'b00;
  localparam logic [1:0] PCS_BR   = 2'b01;
  localparam logic [1:0] PCS_JR   = 2'b10;
  localparam logic [1:0] PCS_JUMP = 2'b11;

  // One-hot decoded instruction plus undefined flag
  typedef struct packed {
    logic i_add;
    logic i_sub;
    logic i_and;
    logic i_or;
    logic i_xor;
    logic i_sll;
    logic i_srl;
    logic i_sra;
    logic i_jr;
    logic i_addi;
    logic i_andi;
    logic i_ori;
    logic i_xori;
    logic i_lw;
    logic i_sw;
    logic i_beq;
    logic i_bne;
    logic i_lui;
    logic i_j;
    logic i_jal;
    logic undef;
  } dec_t;

  // ALU operation for the execute phase; add is the fallback because
  // add, addi, lw and sw all compute a plain sum.
  function automatic logic [3:0] aluc_of(input dec_t d);
    logic [3:0] c;
    c = ALUC_ADD;
    if (d.i_sub | d.i_beq | d.i_bne) c = ALUC_SUB;
    if (d.i_and | d.i_andi)          c = ALUC_AND;
    if (d.i_or  | d.i_ori)           c = ALUC_OR;
    if (d.i_xor | d.i_xori)          c = ALUC_XOR;
    if (d.i_lui)                     c = ALUC_LUI;
    if (d.i_sll)                     c = ALUC_SLL;
    if (d.i_srl)                     c = ALUC_SRL;
    if (d.i_sra)                     c = ALUC_SRA;
    return c;
  endfunction

endpackage

// File: rtl/mc_cu_decode.sv
// mc_decode: combinational instruction decoder for the multicycle CPU.
// Ports:
//   op   in  6  opcode field
//   func in  6  function field (meaningful only when op == 0)
//   dec  out    one-hot i_* flags plus undef for any unsupported code
module mc_decode
  import mc_cu_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    if (op == 6'b000000) begin
      case (func)
        6'b100000: dec.i_add = 1'b1;
        6'b100010: dec.i_sub = 1'b1;
        6'b100100: dec.i_and = 1'b1;
        6'b100101: dec.i_or  = 1'b1;
        6'b100110: dec.i_xor = 1'b1;
        6'b000000: dec.i_sll = 1'b1;
        6'b000010: dec.i_srl = 1'b1;
        6'b000011: dec.i_sra = 1'b1;
        6'b001000: dec.i_jr  = 1'b1;
        default:   dec.undef = 1'b1;
      endcase
    end else begin
      case (op)
        6'b001000: dec.i_addi = 1'b1;
        6'b001100: dec.i_andi = 1'b1;
        6'b001101: dec.i_ori  = 1'b1;
        6'b001110: dec.i_xori = 1'b1;
        6'b100011: dec.i_lw   = 1'b1;
        6'b101011: dec.i_sw   = 1'b1;
        6'b000100: dec.i_beq  = 1'b1;
        6'b000101: dec.i_bne  = 1'b1;
        6'b001111: dec.i_lui  = 1'b1;
        6'b000010: dec.i_j    = 1'b1;
        6'b000011: dec.i_jal  = 1'b1;
        default:   dec.undef  = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mc_cu.sv
// mc_cu: multicycle CPU control unit (FSM plus output logic).
// Ports:
//   clock, resetn        system clock, async active-low reset
//   op, func             instruction fields from the IR
//   z, mem_rdy           ALU zero flag, memory access completes this cycle
//   wpc, wir, wmem, wreg write enables (forced low while in reset)
//   iord                 memory address select (0 PC, 1 ALU)
//   regrt, m2reg, jal, sext, shift  single-cycle style datapath controls
//   alusrca, alusrcb     ALU A/B source selects
//   aluc                 ALU operation
//   pcsource             PC source select
//   state                current FSM state (debug)
module mc_cu
  import mc_cu_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       mem_rdy,
  output logic       wpc,
  output logic       wir,
  output logic       wmem,
  output logic       wreg,
  output logic       iord,
  output logic       regrt,
  output logic       m2reg,
  output logic       jal,
  output logic       sext,
  output logic       shift,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [3:0] aluc,
  output logic [1:0] pcsource,
  output logic [2:0] state
);

  dec_t       dec;
  logic [2:0] next;
  logic       wpc_i, wir_i, wmem_i, wreg_i;
  logic       mem_op, i_alu;

  mc_decode u_decode (
    .op   (op),
    .func (func),
    .dec  (dec)
  );

  assign mem_op = dec.i_lw | dec.i_sw;
  assign i_alu  = dec.i_addi | dec.i_andi | dec.i_ori | dec.i_xori | dec.i_lui;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IF;
    else         state <= next;
  end

  always_comb begin
    wpc_i    = 1'b0;
    wir_i    = 1'b0;
    wmem_i   = 1'b0;
    wreg_i   = 1'b0;
    iord     = 1'b0;
    regrt    = 1'b0;
    m2reg    = 1'b0;
    jal      = 1'b0;
    sext     = 1'b0;
    shift    = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = ASB_FOUR;
    aluc     = ALUC_ADD;
    pcsource = PCS_ALU;
    next     = S_IF;
    case (state)
      S_IF: begin
        wpc_i = mem_rdy;
        wir_i = mem_rdy;
        next  = mem_rdy ? S_ID : S_IF;
      end
      S_ID: begin
        alusrcb = ASB_BOFS;
        if (dec.i_j | dec.i_jal) begin
          wpc_i    = 1'b1;
          pcsource = PCS_JUMP;
          wreg_i   = dec.i_jal;
          jal      = dec.i_jal;
        end else if (dec.i_jr) begin
          wpc_i    = 1'b1;
          pcsource = PCS_JR;
        end else if (!dec.undef) begin
          next = S_EXE;
        end
      end
      // EXE, MEM and WB share one ALU setup so the ALU result (and the
      // controls feeding it) stay put until the register write in WB.
      S_EXE, S_MEM, S_WB: begin
        alusrca = 1'b1;
        aluc    = aluc_of(dec);
        shift   = dec.i_sll | dec.i_srl | dec.i_sra;
        sext    = dec.i_addi | mem_op | dec.i_beq | dec.i_bne;
        alusrcb = (i_alu | mem_op) ? ASB_IMM : ASB_REG;
        case (state)
          S_EXE: begin
            if (dec.i_beq | dec.i_bne) begin
              pcsource = PCS_BR;
              wpc_i    = dec.i_beq ? z : ~z;
              next     = S_IF;
            end else if (mem_op) begin
              next = S_MEM;
            end else begin
              next = S_WB;
            end
          end
          S_MEM: begin
            iord   = 1'b1;
            wmem_i = dec.i_sw & mem_rdy;
            if (mem_rdy) next = dec.i_lw ? S_WB : S_IF;
            else         next = S_MEM;
          end
          default: begin
            wreg_i = 1'b1;
            regrt  = i_alu | dec.i_lw;
            m2reg  = dec.i_lw;
          end
        endcase
      end
      default: next = S_IF;
    endcase
  end

  // Reset gates the enables directly so they drop without waiting for a clock.
  assign wpc  = wpc_i  & resetn;
  assign wir  = wir_i  & resetn;
  assign wmem = wmem_i & resetn;
  assign wreg = wreg_i & resetn;

endmodule

// File: tb/tb_mc_cu.sv
// tb_mc_cu: self-checking bench for mc_cu. Each driven cycle pushes an
// expected output vector and a care mask; a negedge monitor pops and
// compares against the DUT outputs.
module tb_mc_cu;

  logic       clock = 1'b1;
  logic       resetn = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] func = '0;
  logic       z = 1'b0;
  logic       mem_rdy = 1'b1;
  logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift, alusrca;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] aluc;
  logic [2:0] state;

  mc_cu dut (
    .clock(clock), .resetn(resetn), .op(op), .func(func), .z(z), .mem_rdy(mem_rdy),
    .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg), .iord(iord), .regrt(regrt),
    .m2reg(m2reg), .jal(jal), .sext(sext), .shift(shift), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluc(aluc), .pcsource(pcsource), .state(state)
  );

  always #5 clock = ~clock;

  // {state, wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift,
  //  alusrca, alusrcb, aluc, pcsource}
  logic [21:0] obs;
  assign obs = {state, wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift,
                alusrca, alusrcb, aluc, pcsource};

  logic [21:0] exp_q[$];
  logic [21:0] mask_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check_eq(input string tag, input logic [21:0] got, input logic [21:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // en = {wpc, wir, wmem, wreg}; f = {regrt, m2reg, jal, sext, shift}
  function automatic logic [21:0] ev(input logic [2:0] st, input logic [3:0] en,
                                     input logic io, input logic [4:0] f, input logic asa,
                                     input logic [1:0] asb, input logic [3:0] alu,
                                     input logic [1:0] pcs);
    return {st, en, io, f, asa, asb, alu, pcs};
  endfunction

  logic [21:0] m_e, m_m;
  string       m_t;
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      m_m = mask_q.pop_front();
      m_t = tag_q.pop_front();
      check_eq(m_t, obs & m_m, m_e & m_m);
    end
  end

  task automatic cyc(input string tag, input logic [21:0] e, input logic [21:0] m);
    exp_q.push_back(e);
    mask_q.push_back(m);
    tag_q.push_back(tag);
    @(posedge clock);
    #1;
  endtask

  task automatic drv(input logic [5:0] o, input logic [5:0] f, input logic zz, input logic rdy);
    op = o; func = f; z = zz; mem_rdy = rdy;
  endtask

  logic [21:0] MIF, MID, MIDJ, MEXR, MEXI, MEXB, MMEM, MWB;
  logic [21:0] E_IF, E_RST, E_ID;

  task automatic fetch_decode(input string name);
    mem_rdy = 1'b1;
    cyc({name, "_if"}, E_IF, MIF);
    cyc({name, "_id"}, E_ID, MID);
  endtask

  initial begin
    MIF   = ev(3'h7, 4'hF, 1'b1, 5'b00000, 1'b1, 2'h3, 4'hF, 2'h3);
    MID   = ev(3'h7, 4'hF, 1'b0, 5'b00000, 1'b1, 2'h3, 4'hF, 2'h0);
    MIDJ  = ev(3'h7, 4'hF, 1'b0, 5'b00100, 1'b1, 2'h3, 4'hF, 2'h3);
    MEXR  = ev(3'h7, 4'hF, 1'b0, 5'b10001, 1'b1, 2'h3, 4'hF, 2'h0);
    MEXI  = ev(3'h7, 4'hF, 1'b0, 5'b00010, 1'b1, 2'h3, 4'hF, 2'h0);
    MEXB  = ev(3'h7, 4'hF, 1'b0, 5'b00000, 1'b0, 2'h3, 4'hF, 2'h3);
    MMEM  = ev(3'h7, 4'hF, 1'b1, 5'b00000, 1'b0, 2'h0, 4'h0, 2'h0);
    MWB   = ev(3'h7, 4'hF, 1'b0, 5'b11000, 1'b0, 2'h0, 4'hF, 2'h0);
    E_IF  = ev(3'd0, 4'b1100, 1'b0, 5'b0, 1'b0, 2'b01, 4'h0, 2'b00);
    E_RST = ev(3'd0, 4'b0000, 1'b0, 5'b0, 1'b0, 2'b01, 4'h0, 2'b00);
    E_ID  = ev(3'd1, 4'b0000, 1'b0, 5'b0, 1'b0, 2'b11, 4'h0, 2'b00);

    // reset with mem_rdy=1: enables must stay low, IF values elsewhere
    drv(6'b000000, 6'b100000, 1'b0, 1'b1);
    cyc("rst", E_RST, MIF);
    cyc("rst_hold", E_RST, MIF);
    resetn = 1'b1;

    // add: 0,1,2,4
    fetch_decode("add");
    cyc("add_exe", ev(3'd2, 4'b0000, 1'b0, 5'b00000, 1'b1, 2'b00, 4'b0000, 2'b00), MEXR);
    cyc("add_wb",  ev(3'd4, 4'b0001, 1'b0, 5'b00000, 1'b0, 2'b00, 4'b0000, 2'b00), MWB);

    // fetch stall then sra
    drv(6'b000000, 6'b000011, 1'b0, 1'b0);
    cyc("if_stall", E_RST, MIF);
    fetch_decode("sra");
    cyc("sra_exe", ev(3'd2, 4'b0000, 1'b0, 5'b00001, 1'b1, 2'b00, 4'b1111, 2'b00), MEXR);
    cyc("sra_wb",  ev(3'd4, 4'b0001, 1'b0, 5'b00000, 1'b0, 2'b00, 4'b1111, 2'b00), MWB);

    // ori: zero-extended immediate, regrt in WB
    drv(6'b001101, 6'b000000, 1'b0, 1'b1);
    fetch_decode("ori");
    cyc("ori_exe", ev(3'd2, 4'b0000, 1'b0, 5'b00000, 1'b1, 2'b10, 4'b0101, 2'b00), MEXI);
    cyc("ori_wb",  ev(3'd4, 4'b0001, 1'b0, 5'b10000, 1'b0, 2'b00, 4'b0101, 2'b00), MWB);

    // lw with two memory wait cycles: 0,1,2,3,3,3,4
    drv(6'b100011, 6'b000000, 1'b0, 1'b1);
    fetch_decode("lw");
    cyc("lw_exe", ev(3'd2, 4'b0000, 1'b0, 5'b00010, 1'b1, 2'b10, 4'b0000, 2'b00), MEXI);
    mem_rdy = 1'b0;
    cyc("lw_mem0", ev(3'd3, 4'b0000, 1'b1, 5'b0, 1'b0, 2'b00, 4'h0, 2'b00), MMEM);
    cyc("lw_mem1", ev(3'd3, 4'b0000, 1'b1, 5'b0, 1'b0, 2'b00, 4'h0, 2'b00), MMEM);
    mem_rdy = 1'b1;
    cyc("lw_mem2", ev(3'd3, 4'b0000, 1'b1, 5'b0, 1'b0, 2'b00, 4'h0, 2'b00), MMEM);
    cyc("lw_wb", ev(3'd4, 4'b0001, 1'b0, 5'b11000, 1'b0, 2'b00, 4'b0000, 2'b00), MWB);

    // sw completing at once: wmem for one cycle, then IF
    drv(6'b101011, 6'b000000, 1'b0, 1'b1);
    fetch_decode("sw");
    cyc("sw_exe", ev(3'd2, 4'b0000, 1'b0, 5'b00010, 1'b1, 2'b10, 4'b0000, 2'b00), MEXI);
    cyc("sw_mem", ev(3'd3, 4'b0010, 1'b1, 5'b0, 1'b0, 2'b00, 4'h0, 2'b00), MMEM);

    // branches
    drv(6'b000100, 6'b000000, 1'b1, 1'b1);
    fetch_decode("beq1");
    cyc("beq1_exe", ev(3'd2, 4'b1000, 1'b0, 5'b0, 1'b0, 2'b00, 4'b0100, 2'b01), MEXB);
    drv(6'b000100, 6'b000000, 1'b0, 1'b1);
    fetch_decode("beq0");
    cyc("beq0_exe", ev(3'd2, 4'b0000, 1'b0, 5'b0, 1'b0, 2'b00, 4'b0100, 2'b01), MEXB);
    drv(6'b000101, 6'b000000, 1'b0, 1'b1);
    fetch_decode("bne0");
    cyc("bne0_exe", ev(3'd2, 4'b1000, 1'b0, 5'b0, 1'b0, 2'b00, 4'b0100, 2'b01), MEXB);

    // jumps resolve in ID and return to IF
    drv(6'b000011, 6'b000000, 1'b0, 1'b1);
    cyc("jal_if", E_IF, MIF);
    cyc("jal_id", ev(3'd1, 4'b1001, 1'b0, 5'b00100, 1'b0, 2'b11, 4'h0, 2'b11), MIDJ);
    drv(6'b000010, 6'b000000, 1'b0, 1'b1);
    cyc("j_if", E_IF, MIF);
    cyc("j_id", ev(3'd1, 4'b1000, 1'b0, 5'b00000, 1'b0, 2'b11, 4'h0, 2'b11), MIDJ);
    drv(6'b000000, 6'b001000, 1'b0, 1'b1);
    cyc("jr_if", E_IF, MIF);
    cyc("jr_id", ev(3'd1, 4'b1000, 1'b0, 5'b00000, 1'b0, 2'b11, 4'h0, 2'b10), MIDJ);

    // undefined opcode: 0,1,0, no enables
    drv(6'b111111, 6'b000000, 1'b0, 1'b1);
    fetch_decode("undef");

    // sw with reset dropped mid-MEM, memory becoming ready at the same time
    drv(6'b101011, 6'b000000, 1'b0, 1'b1);
    cyc("swr_if", E_IF, MIF);
    cyc("swr_id", E_ID, MID);
    cyc("swr_exe", ev(3'd2, 4'b0000, 1'b0, 5'b00010, 1'b1, 2'b10, 4'b0000, 2'b00), MEXI);
    mem_rdy = 1'b0;
    cyc("swr_mem", ev(3'd3, 4'b0000, 1'b1, 5'b0, 1'b0, 2'b00, 4'h0, 2'b00), MMEM);
    mem_rdy = 1'b1;
    resetn = 1'b0;
    cyc("swr_rst", E_RST, MIF);
    cyc("swr_rst_hold", E_RST, MIF);
    resetn = 1'b1;
    cyc("swr_refetch", E_IF, MIF);
    cyc("swr_id2", E_ID, MID);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clock);
    #1;
    check_eq("drain", 22'(exp_q.size()), 22'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
